// File: rtl/breakout_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : breakout_pkg
//  Purpose  : Shared Breakout definitions: game-flow state encoding, default
//             game-controller settings and screen limits used by the ball
//             mover.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package breakout_pkg;

   // Game-flow states. The values are visible on the LEDs, so they are fixed.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_MISS  = 3'd3,
      ST_OVER  = 3'd4,
      ST_WIN   = 3'd5
   } state_t;

   // Default game-controller settings
   localparam int c_lives_dflt          = 3;
   localparam int c_lives_w_dflt        = 2;
   localparam int c_serve_ticks_dflt    = 60;
   localparam int c_hits_per_level_dflt = 8;
   localparam int c_max_level_dflt      = 7;
   localparam int c_score_w_dflt        = 10;
   localparam int c_level_w             = 3;

   // Screen limits shared with the ball mover
   localparam int c_screen_w            = 640;
   localparam int c_screen_h            = 480;

endpackage
`default_nettype wire

// File: rtl/game_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl_if
//  Purpose  : Bundle of game-controller signals between the sequencer and
//             the board/ball mover/brick field.
//  Ports    : frame_tick, start_btn, endgame, hit_bar, brick_hit,
//             bricks_left_zero (into the sequencer); ball_run, lives, score,
//             speed_level, state, game_over, win (out of the sequencer).
//             modport slave  : used by game_ctrl
//             modport master : used by the surrounding system / testbench
//  Revision : 1.0 - initial release
// ============================================================================
interface game_ctrl_if #(
   parameter int LIVES_W = 2,
   parameter int SCORE_W = 10
);
   logic               frame_tick;
   logic               start_btn;
   logic               endgame;
   logic               hit_bar;
   logic               brick_hit;
   logic               bricks_left_zero;
   logic               ball_run;
   logic [LIVES_W-1:0] lives;
   logic [SCORE_W-1:0] score;
   logic [2:0]         speed_level;
   logic [2:0]         state;
   logic               game_over;
   logic               win;

   modport slave (
      input  frame_tick, start_btn, endgame, hit_bar, brick_hit, bricks_left_zero,
      output ball_run, lives, score, speed_level, state, game_over, win
   );

   modport master (
      output frame_tick, start_btn, endgame, hit_bar, brick_hit, bricks_left_zero,
      input  ball_run, lives, score, speed_level, state, game_over, win
   );
endinterface
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module   : rise_detect
//  Purpose  : One-bit rising-edge detector. The delay register updates every
//             cycle; rise is high for the first cycle din is seen high.
//  Ports    : clock, reset (sync, active-high), din (level), rise (pulse)
//  Revision : 1.0 - initial release
// ============================================================================
module rise_detect (
   input  wire logic clock,
   input  wire logic reset,
   input  wire logic din,
   output logic      rise
);
   logic r_din_q;

   always_ff @(posedge clock) begin
      if (reset) r_din_q <= 1'b0;
      else       r_din_q <= din;
   end

   assign rise = din & ~r_din_q;
endmodule
`default_nettype wire

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_ctrl
//  Purpose  : Breakout game sequencer. Runs the game flow (idle, serve, play,
//             miss, over, win), gates the ball mover via ball_run and keeps
//             lives, score and speed level.
//  Ports    : clock, reset (sync, active-high)
//             bus (game_ctrl_if.slave): frame_tick, start_btn, endgame,
//             hit_bar, brick_hit, bricks_left_zero in; ball_run, lives,
//             score, speed_level, state, game_over, win out.
//  Revision : 1.0 - initial release
// ============================================================================
module game_ctrl
   import breakout_pkg::*;
#(
   parameter int LIVES          = c_lives_dflt,
   parameter int LIVES_W        = c_lives_w_dflt,
   parameter int SERVE_TICKS    = c_serve_ticks_dflt,
   parameter int HITS_PER_LEVEL = c_hits_per_level_dflt,
   parameter int MAX_LEVEL      = c_max_level_dflt,
   parameter int SCORE_W        = c_score_w_dflt
) (
   input  wire logic     clock,
   input  wire logic     reset,
   game_ctrl_if.slave    bus
);
   localparam int c_serve_w = $clog2(SERVE_TICKS + 1);
   localparam int c_hit_w   = $clog2(HITS_PER_LEVEL + 1);

   localparam logic [c_serve_w-1:0] c_serve_last = c_serve_w'(SERVE_TICKS - 1);
   localparam logic [c_hit_w-1:0]   c_hit_last   = c_hit_w'(HITS_PER_LEVEL - 1);
   localparam logic [c_level_w-1:0] c_max_level  = c_level_w'(MAX_LEVEL);
   localparam logic [LIVES_W-1:0]   c_lives_load = LIVES_W'(LIVES);

   state_t                 r_state;
   logic [LIVES_W-1:0]     r_lives;
   logic [SCORE_W-1:0]     r_score;
   logic [c_level_w-1:0]   r_level;
   logic [c_serve_w-1:0]   r_serve_cnt;
   logic [c_hit_w-1:0]     r_hit_cnt;

   logic                   w_start_rise;
   logic                   w_bar_rise;

   rise_detect u_start_rise (
      .clock (clock),
      .reset (reset),
      .din   (bus.start_btn),
      .rise  (w_start_rise)
   );

   // hit_bar stays high while the ball overlaps the bar, so only its
   // leading edge counts as one bar hit.
   rise_detect u_bar_rise (
      .clock (clock),
      .reset (reset),
      .din   (bus.hit_bar),
      .rise  (w_bar_rise)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_lives     <= '0;
         r_score     <= '0;
         r_level     <= '0;
         r_serve_cnt <= '0;
         r_hit_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start_rise) begin
                  r_state     <= ST_SERVE;
                  r_lives     <= c_lives_load;
                  r_score     <= '0;
                  r_level     <= '0;
                  r_serve_cnt <= '0;
                  r_hit_cnt   <= '0;
               end
            end

            ST_SERVE: begin
               if (bus.frame_tick) begin
                  if (r_serve_cnt == c_serve_last) begin
                     r_state     <= ST_PLAY;
                     r_serve_cnt <= '0;
                  end else begin
                     r_serve_cnt <= r_serve_cnt + c_serve_w'(1);
                  end
               end
            end

            ST_PLAY: begin
               // Scoring and speed-up happen even on the cycle we leave PLAY,
               // so the brick that clears the field still counts.
               if (bus.brick_hit && (r_score != '1))
                  r_score <= r_score + SCORE_W'(1);

               if (w_bar_rise) begin
                  if (r_hit_cnt == c_hit_last) begin
                     r_hit_cnt <= '0;
                     if (r_level < c_max_level)
                        r_level <= r_level + c_level_w'(1);
                  end else begin
                     r_hit_cnt <= r_hit_cnt + c_hit_w'(1);
                  end
               end

               if (bus.bricks_left_zero)  r_state <= ST_WIN;
               else if (bus.endgame)      r_state <= ST_MISS;
            end

            // Single cycle with the ball frozen so the mover can drop endgame.
            ST_MISS: begin
               if (r_lives <= LIVES_W'(1)) begin
                  r_lives <= '0;
                  r_state <= ST_OVER;
               end else begin
                  r_lives     <= r_lives - LIVES_W'(1);
                  r_serve_cnt <= '0;
                  r_state     <= ST_SERVE;
               end
            end

            ST_OVER, ST_WIN: begin
               if (w_start_rise) r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Moore decode of registered state and counters
   assign bus.ball_run    = (r_state == ST_PLAY);
   assign bus.game_over   = (r_state == ST_OVER);
   assign bus.win         = (r_state == ST_WIN);
   assign bus.state       = r_state;
   assign bus.lives       = r_lives;
   assign bus.score       = r_score;
   assign bus.speed_level = r_level;
endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_ctrl
//  Purpose  : Self-checking bench for game_ctrl against a behavioural model
//             that tracks whole-game totals (bricks, bar hits, serve ticks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;
   localparam int c_lives   = 3;
   localparam int c_serve   = 60;
   localparam int c_hpl     = 8;
   localparam int c_max_lvl = 7;
   localparam int c_score_w = 10;
   localparam int c_score_max = (1 << c_score_w) - 1;

   localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_MISS = 3, S_OVER = 4, S_WIN = 5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   game_ctrl_if #(.LIVES_W(2), .SCORE_W(c_score_w)) bus ();

   game_ctrl #(
      .LIVES(c_lives), .LIVES_W(2), .SERVE_TICKS(c_serve),
      .HITS_PER_LEVEL(c_hpl), .MAX_LEVEL(c_max_lvl), .SCORE_W(c_score_w)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: game totals rather than the design's internal counters
   int m_state = S_IDLE;
   int m_lives = 0;
   int m_bricks = 0;
   int m_bars = 0;
   int m_ticks = 0;
   bit m_start_q = 0;
   bit m_bar_q = 0;

   function automatic int m_score();
      return (m_bricks > c_score_max) ? c_score_max : m_bricks;
   endfunction

   function automatic int m_level();
      return ((m_bars / c_hpl) > c_max_lvl) ? c_max_lvl : (m_bars / c_hpl);
   endfunction

   // {state, lives, score, speed_level, ball_run, game_over, win}
   function automatic logic [20:0] exp_vec();
      return {3'(m_state), 2'(m_lives), 10'(m_score()), 3'(m_level()),
              m_state == S_PLAY, m_state == S_OVER, m_state == S_WIN};
   endfunction

   function automatic logic [20:0] act_vec();
      return {bus.state, bus.lives, bus.score, bus.speed_level,
              bus.ball_run, bus.game_over, bus.win};
   endfunction

   // Advance one clock: update the model from the inputs as they are now,
   // then let the DUT take the edge and sample 1 ns later.
   task automatic tick();
      bit s_rise, b_rise;
      s_rise = bus.start_btn && !m_start_q;
      b_rise = bus.hit_bar && !m_bar_q;
      if (reset) begin
         m_state = S_IDLE; m_lives = 0; m_bricks = 0; m_bars = 0; m_ticks = 0;
         m_start_q = 0; m_bar_q = 0;
      end else begin
         case (m_state)
            S_IDLE: if (s_rise) begin
               m_state = S_SERVE; m_lives = c_lives; m_bricks = 0; m_bars = 0; m_ticks = 0;
            end
            S_SERVE: if (bus.frame_tick) begin
               m_ticks++;
               if (m_ticks == c_serve) begin m_state = S_PLAY; m_ticks = 0; end
            end
            S_PLAY: begin
               if (bus.brick_hit) m_bricks++;
               if (b_rise) m_bars++;
               if (bus.bricks_left_zero) m_state = S_WIN;
               else if (bus.endgame)     m_state = S_MISS;
            end
            S_MISS: begin
               if (m_lives <= 1) begin m_lives = 0; m_state = S_OVER; end
               else begin m_lives--; m_ticks = 0; m_state = S_SERVE; end
            end
            default: if (s_rise) m_state = S_IDLE;
         endcase
         m_start_q = bus.start_btn;
         m_bar_q = bus.hit_bar;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      bus.frame_tick = 0; bus.start_btn = 0; bus.endgame = 0;
      bus.hit_bar = 0; bus.brick_hit = 0; bus.bricks_left_zero = 0;
   endtask

   task automatic press_start();
      bus.start_btn = 1; tick();
      bus.start_btn = 0; tick();
   endtask

   task automatic serve_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.frame_tick = 1; tick();
         bus.frame_tick = 0; tick();
      end
   endtask

   task automatic bar_hits(input int n);
      for (int i = 0; i < n; i++) begin
         bus.hit_bar = 1; repeat (5) tick();
         bus.hit_bar = 0; repeat (2) tick();
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; tick(); tick();
      reset = 0; tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL reset_vec: got %h expected %h", act_vec(), exp_vec());
      end
      n_checks++;
      if ({bus.state, bus.lives, bus.ball_run} !== 6'b0) begin
         n_fail++; $display("FAIL reset_zero: got state=%0d lives=%0d run=%0b expected 0/0/0",
                            bus.state, bus.lives, bus.ball_run);
      end
   endtask

   task automatic test_serve();
      bus.start_btn = 1; tick();
      n_checks++;
      if (bus.state !== 3'd1 || bus.lives !== 2'd3 || bus.score !== 10'd0) begin
         n_fail++; $display("FAIL start_load: got state=%0d lives=%0d score=%0d expected 1/3/0",
                            bus.state, bus.lives, bus.score);
      end
      bus.start_btn = 0; tick();
      serve_ticks(c_serve - 1);
      n_checks++;
      if (bus.state !== 3'd1 || bus.ball_run !== 1'b0) begin
         n_fail++; $display("FAIL serve_hold: got state=%0d run=%0b expected 1/0", bus.state, bus.ball_run);
      end
      bus.frame_tick = 1; tick();
      bus.frame_tick = 0;
      n_checks++;
      if (bus.state !== 3'd2 || bus.ball_run !== 1'b1) begin
         n_fail++; $display("FAIL serve_done: got state=%0d run=%0b expected 2/1", bus.state, bus.ball_run);
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL serve_vec: got %h expected %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_speed();
      bar_hits(c_hpl);
      n_checks++;
      if (bus.speed_level !== 3'd1) begin
         n_fail++; $display("FAIL level_one: got %0d expected 1", bus.speed_level);
      end
      bar_hits(64 - c_hpl);
      n_checks++;
      if (bus.speed_level !== 3'd7) begin
         n_fail++; $display("FAIL level_sat: got %0d expected 7", bus.speed_level);
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL speed_vec: got %h expected %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_win();
      for (int i = 0; i < 3; i++) begin
         bus.brick_hit = 1; bus.bricks_left_zero = (i == 2); tick();
         bus.brick_hit = 0; bus.bricks_left_zero = 0; tick();
      end
      n_checks++;
      if (bus.score !== 10'd3 || bus.state !== 3'd5 || bus.win !== 1'b1 || bus.ball_run !== 1'b0) begin
         n_fail++; $display("FAIL win: got score=%0d state=%0d win=%0b run=%0b expected 3/5/1/0",
                            bus.score, bus.state, bus.win, bus.ball_run);
      end
      bus.brick_hit = 1; bus.hit_bar = 1; tick();
      bus.brick_hit = 0; bus.hit_bar = 0; tick();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL win_hold: got %h expected %h", act_vec(), exp_vec());
      end
      press_start();
      n_checks++;
      if (bus.state !== 3'd0) begin
         n_fail++; $display("FAIL win_to_idle: got state=%0d expected 0", bus.state);
      end
   endtask

   task automatic test_lives();
      press_start();
      for (int i = 0; i < 3; i++) begin
         serve_ticks(c_serve);
         bus.endgame = 1; tick();
         bus.endgame = 0; tick();
         n_checks++;
         if (bus.lives !== 2'(2 - i) || bus.state !== ((i == 2) ? 3'd4 : 3'd1)) begin
            n_fail++; $display("FAIL miss_%0d: got lives=%0d state=%0d expected %0d/%0d",
                               i, bus.lives, bus.state, 2 - i, (i == 2) ? 4 : 1);
         end
      end
      n_checks++;
      if (bus.game_over !== 1'b1 || act_vec() !== exp_vec()) begin
         n_fail++; $display("FAIL over: got %h expected %h", act_vec(), exp_vec());
      end
      press_start();
      n_checks++;
      if (bus.state !== 3'd0 || bus.game_over !== 1'b0) begin
         n_fail++; $display("FAIL over_to_idle: got state=%0d expected 0", bus.state);
      end
   endtask

   task automatic test_reset_mid();
      press_start();
      serve_ticks(c_serve);
      for (int i = 0; i < 5; i++) begin
         bus.brick_hit = 1; tick();
         bus.brick_hit = 0; tick();
      end
      bar_hits(2 * c_hpl);
      n_checks++;
      if (bus.score !== 10'd5 || bus.speed_level !== 3'd2 || bus.state !== 3'd2) begin
         n_fail++; $display("FAIL mid_setup: got score=%0d level=%0d state=%0d expected 5/2/2",
                            bus.score, bus.speed_level, bus.state);
      end
      reset = 1; tick();
      reset = 0;
      n_checks++;
      if ({bus.state, bus.score, bus.speed_level, bus.lives, bus.ball_run} !== 19'd0) begin
         n_fail++; $display("FAIL mid_reset: got state=%0d score=%0d level=%0d lives=%0d run=%0b expected all 0",
                            bus.state, bus.score, bus.speed_level, bus.lives, bus.ball_run);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 20000; i++) begin
         reset = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 29) == 0) bus.start_btn = ~bus.start_btn;
         if ($urandom_range(0, 3) == 0)  bus.hit_bar = ~bus.hit_bar;
         bus.frame_tick       = ($urandom_range(0, 1) == 0);
         bus.endgame          = ($urandom_range(0, 99) == 0);
         bus.brick_hit        = ($urandom_range(0, 3) == 0);
         bus.bricks_left_zero = ($urandom_range(0, 599) == 0);
         tick();
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            if (errs < 10) $display("FAIL random cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            errs++;
         end
      end
      reset = 0;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_serve();
      test_speed();
      test_win();
      test_lives();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
